serializer: RTL and testbench

Parallel-to-serial converter. Captures a WIDTH-bit word on a one-cycle load strobe and shifts it out MSB-first, one bit per clock, on a single-wire output. Used on the self-test path to stream test words onto a serial link. Provides busy, valid and done status to the upstream controller.

---
 rtl/serializer_pkg.sv | 13 +
 rtl/piso_shreg.sv | 41 ++++
 rtl/serializer.sv | 107 ++++++++++
 tb/tb_serializer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
// Shared types and constants for the parallel-to-serial converter.
package serializer_pkg;

    // Controller states: waiting for a load strobe, or streaming a word out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default word length.
    localparam int DEFAULT_WIDTH = 32;

endpackage : serializer_pkg

// File: rtl/piso_shreg.sv
// Loadable parallel-in/serial-out shift register. The head bit is a register
// bit, so o_head is a registered output. Shifting pulls IDLE_LEVEL in behind
// the payload, so one shift past the last payload bit returns the line to idle.
module piso_shreg
    import serializer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_head
);

    logic [WIDTH-1:0] r_shreg;

    // Load has priority over shift; reset fills with the idle level.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the shift register is reset because its head bit drives
            // the serial line directly; it must show the idle level out of reset.
            r_shreg <= {WIDTH{IDLE_LEVEL}};
        end else if (i_load) begin
            r_shreg <= i_data;
        end else if (i_shift) begin
            if (MSB_FIRST) begin
                r_shreg <= {r_shreg[WIDTH-2:0], IDLE_LEVEL};
            end else begin
                r_shreg <= {IDLE_LEVEL, r_shreg[WIDTH-1:1]};
            end
        end
    end

    assign o_head = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

endmodule : piso_shreg

// File: rtl/serializer.sv
// Parallel-to-serial converter: captures a word on an accepted load strobe and
// streams it out one bit per clock, with busy / bit_valid / done status.
module serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output logic             data_out,
    output logic             busy,
    output logic             bit_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_bit_valid;
    logic          r_done;

    logic          w_last;
    logic          w_accept;
    logic          w_shift;
    logic          w_head;

    // A strobe is honoured only when idle or while the last bit is on the line.
    assign w_last   = (r_state == SHIFT) && (r_cnt == '0);
    assign w_accept = en && ((r_state == IDLE) || w_last);
    // Shifting past the last bit pulls the idle level onto the line.
    assign w_shift  = (r_state == SHIFT);

    piso_shreg #(
        .WIDTH      (WIDTH),
        .MSB_FIRST  (MSB_FIRST),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (data_in),
        .o_head  (w_head)
    );

    // Controller FSM with bit counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_bit_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state     <= SHIFT;
                        r_cnt       <= LAST_IDX;
                        r_busy      <= 1'b1;
                        r_bit_valid <= 1'b1;
                        r_done      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (r_cnt == '0) begin
                        if (en) begin
                            // Back-to-back word: first bit follows with no gap.
                            r_cnt       <= LAST_IDX;
                            r_busy      <= 1'b1;
                            r_bit_valid <= 1'b1;
                            r_done      <= 1'b0;
                        end else begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_bit_valid <= 1'b0;
                            r_done      <= 1'b0;
                        end
                    end else begin
                        r_cnt  <= r_cnt - 1'b1;
                        r_done <= (r_cnt == CW'(1));
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_busy      <= 1'b0;
                    r_bit_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = w_head;
    assign busy      = r_busy;
    assign bit_valid = r_bit_valid;
    assign done      = r_done;

endmodule : serializer

// File: tb/tb_serializer.sv
// Directed self-checking bench for the serializer (MSB-first and LSB-first).
module tb_serializer;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] data_in;
    logic        data_out;
    logic        busy;
    logic        bit_valid;
    logic        done;

    logic        en_l;
    logic [31:0] data_in_l;
    logic        data_out_l;
    logic        busy_l;
    logic        bit_valid_l;
    logic        done_l;

    int checks   = 0;
    int failures = 0;

    serializer #(.WIDTH(32), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .bit_valid (bit_valid),
        .done      (done)
    );

    serializer #(.WIDTH(32), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .en        (en_l),
        .data_in   (data_in_l),
        .data_out  (data_out_l),
        .busy      (busy_l),
        .bit_valid (bit_valid_l),
        .done      (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are stable 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the MSB-first instance for one cycle, then advance a cycle.
    task automatic cyc(input string tag, input logic exp_bit, input logic exp_valid,
                       input logic exp_done);
        check({tag, ".data_out"},  64'(data_out),  64'(exp_bit));
        check({tag, ".bit_valid"}, 64'(bit_valid), 64'(exp_valid));
        check({tag, ".busy"},      64'(busy),      64'(exp_valid));
        check({tag, ".done"},      64'(done),      64'(exp_done));
        tick();
    endtask

    // Accept a word on the MSB-first instance (strobe sampled at the next edge).
    task automatic load(input logic [31:0] word);
        en      = 1'b1;
        data_in = word;
        tick();
        en      = 1'b0;
    endtask

    initial begin
        logic [31:0] word;
        logic [63:0] stream;
        logic [31:0] pattern;

        rst       = 1'b1;
        en        = 1'b1;
        data_in   = 32'hFFFF_FFFF;
        en_l      = 1'b1;
        data_in_l = 32'hFFFF_FFFF;

        // Reset held with en=1: everything stays idle.
        for (int c = 0; c < 2; c++) begin
            tick();
            check("rst.data_out",  64'(data_out),  64'd0);
            check("rst.busy",      64'(busy),      64'd0);
            check("rst.bit_valid", 64'(bit_valid), 64'd0);
            check("rst.done",      64'(done),      64'd0);
            check("rst.lsb_busy",  64'(busy_l),    64'd0);
        end
        rst  = 1'b0;
        en   = 1'b0;
        en_l = 1'b0;
        tick();
        cyc("idle", 1'b0, 1'b0, 1'b0);

        // Single word, MSB first; the stream is also checked against the
        // hand-written bit pattern of 0xFE1269FF.
        word    = 32'hFE12_69FF;
        pattern = 32'b1111_1110_0001_0010_0110_1001_1111_1111;
        check("single.pattern", 64'(pattern), 64'(32'hFE12_69FF));
        load(word);
        for (int i = 0; i < 32; i++) begin
            cyc("single", pattern[31-i], 1'b1, (i == 31));
        end
        cyc("single.after", 1'b0, 1'b0, 1'b0);

        // Strobe at bit 10 of an all-ones word is ignored.
        load(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) begin
            en      = (i == 10);
            data_in = (i == 10) ? 32'h0000_0000 : 32'hFFFF_FFFF;
            cyc("ignored", 1'b1, 1'b1, (i == 31));
        end
        en = 1'b0;
        cyc("ignored.after0", 1'b0, 1'b0, 1'b0);
        cyc("ignored.after1", 1'b0, 1'b0, 1'b0);

        // Back-to-back: strobe on the done cycle gives 64 contiguous bits.
        stream = {32'hAAAA_AAAA, 32'h0000_FFFF};
        load(32'hAAAA_AAAA);
        for (int i = 0; i < 64; i++) begin
            en      = (i == 31);
            data_in = (i == 31) ? 32'h0000_FFFF : 32'h1234_5678;
            cyc("b2b", stream[63-i], 1'b1, (i == 31) || (i == 63));
        end
        en = 1'b0;
        cyc("b2b.after", 1'b0, 1'b0, 1'b0);

        // Reset at bit 5 of 0x80000001: the trailing 1 never appears.
        word = 32'h8000_0001;
        load(word);
        for (int i = 0; i < 6; i++) begin
            rst = (i == 5);
            cyc("midrst", word[31-i], 1'b1, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc("midrst.after", 1'b0, 1'b0, 1'b0);
        end

        // LSB-first instance with 0x00000001: first bit 1, then 31 zeros.
        word      = 32'h0000_0001;
        en_l      = 1'b1;
        data_in_l = word;
        tick();
        en_l      = 1'b0;
        data_in_l = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) begin
            check("lsb.data_out",  64'(data_out_l),  64'(word[i]));
            check("lsb.bit_valid", 64'(bit_valid_l), 64'd1);
            check("lsb.done",      64'(done_l),      64'(i == 31));
            tick();
        end
        check("lsb.after.busy",     64'(busy_l),     64'd0);
        check("lsb.after.data_out", 64'(data_out_l), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serializer
